pipelined_barrel_shifter: RTL and testbench

Parametrised, fully pipelined barrel shifter for the ALU datapath, WIDTH bits wide.
- Supports logical right, arithmetic right and logical left shifts, plus rotate-right when compiled in.
- One register stage per shift level, so LOG2W levels give LOG2W cycles of latency.
- Valid/ready handshake on both sides with per-stage bubble collapsing, so the core can stall the result without losing data.

---
 rtl/shifter_pkg.sv | 17 +
 rtl/shift_stage.sv | 81 ++++++++
 rtl/pipelined_barrel_shifter.sv | 70 +++++++
 tb/tb_pipelined_barrel_shifter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter.
//   shift_op_t : 2-bit operation code carried down the pipeline
//   OP_SRL     : logical right shift, zero fill
//   OP_SRA     : arithmetic right shift, sign fill
//   OP_SLL     : logical left shift, zero fill
//   OP_ROR     : rotate right (only when SHIFTER_ROTATE_EN is defined,
//                otherwise treated as OP_SRL)
package shifter_pkg;

   typedef logic [1:0] shift_op_t;

   localparam shift_op_t OP_SRL = 2'b00;
   localparam shift_op_t OP_SRA = 2'b01;
   localparam shift_op_t OP_SLL = 2'b10;
   localparam shift_op_t OP_ROR = 2'b11;

endpackage

// File: rtl/shift_stage.sv
// One level of the pipelined barrel shifter: shifts by 2^K when bit K of the
// carried amount is set, and registers valid/data/amt/op.
// Optional build macro: SHIFTER_ROTATE_EN (adds the rotate-right wrap mux).
// Ports:
//   clock, reset         : clock, synchronous active-high reset
//   up_valid/data/amt/op : values from the previous stage (or the inputs)
//   down_adv             : advance signal of the next stage (out_ready at the end)
//   adv                  : this stage loads upstream values this cycle
//   valid/data/amt/op    : this stage's registers
module shift_stage
   import shifter_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int LOG2W = $clog2(WIDTH),
   parameter int K     = 0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             up_valid,
   input  logic [WIDTH-1:0] up_data,
   input  logic [LOG2W-1:0] up_amt,
   input  shift_op_t        up_op,
   input  logic             down_adv,
   output logic             adv,
   output logic             valid,
   output logic [WIDTH-1:0] data,
   output logic [LOG2W-1:0] amt,
   output shift_op_t        op
);

   localparam int SH = 1 << K;

   logic             valid_reg;
   logic [WIDTH-1:0] data_reg;
   logic [LOG2W-1:0] amt_reg;
   shift_op_t        op_reg;
   logic [WIDTH-1:0] shifted;

   // SRA uses the MSB of this stage's input; earlier stages have already
   // sign-extended, so that MSB is still the original operand sign.
   always_comb begin
      shifted = up_data;
      if (up_amt[K]) begin
         case (up_op)
            OP_SRA:  shifted = $unsigned($signed(up_data) >>> SH);
            OP_SLL:  shifted = up_data << SH;
`ifdef SHIFTER_ROTATE_EN
            OP_ROR:  shifted = {up_data[SH-1:0], up_data[WIDTH-1:SH]};
`endif
            default: shifted = up_data >> SH;
         endcase
      end
   end

   // An empty stage always accepts, so bubbles collapse under back-pressure.
   assign adv = !valid_reg || down_adv;

   always_ff @(posedge clock) begin
      if (reset) begin
         valid_reg <= 1'b0;
         data_reg  <= '0;
         amt_reg   <= '0;
         op_reg    <= OP_SRL;
      end else if (adv) begin
         valid_reg <= up_valid;
         // Payload only moves with a real operation, so idle cycles leave
         // the data registers untouched.
         if (up_valid) begin
            data_reg <= shifted;
            amt_reg  <= up_amt;
            op_reg   <= up_op;
         end
      end
   end

   assign valid = valid_reg;
   assign data  = data_reg;
   assign amt   = amt_reg;
   assign op    = op_reg;

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Fully pipelined barrel shifter, one register stage per shift level
// (LOG2W cycles of latency, one operation per cycle throughput), with
// valid/ready handshakes on both sides.
// Optional build macro: SHIFTER_ROTATE_EN (op 11 = rotate right; otherwise SRL).
// Ports:
//   clock, reset                   : clock, synchronous active-high reset
//   in_valid, in_ready             : input handshake
//   in_data, in_amt, in_op         : operand, shift amount, operation
//   out_valid, out_ready, out_data : output handshake and registered result
module pipelined_barrel_shifter
   import shifter_pkg::*;
#(
   parameter  int WIDTH = 32,
   localparam int LOG2W = $clog2(WIDTH)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [LOG2W-1:0] in_amt,
   input  logic [1:0]       in_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   // Index 0 of each chain is the input side; stage k drives index k+1.
   // The advance chain runs the other way: adv_c[k] belongs to stage k and
   // adv_c[LOG2W] is the downstream ready.
   logic             valid_c [0:LOG2W];
   logic [WIDTH-1:0] data_c  [0:LOG2W];
   logic [LOG2W-1:0] amt_c   [0:LOG2W];
   shift_op_t        op_c    [0:LOG2W];
   logic             adv_c   [0:LOG2W];

   assign valid_c[0]   = in_valid;
   assign data_c[0]    = in_data;
   assign amt_c[0]     = in_amt;
   assign op_c[0]      = in_op;
   assign adv_c[LOG2W] = out_ready;

   generate
      for (genvar gi = 0; gi < LOG2W; gi++) begin : g_stage
         shift_stage #(
            .WIDTH (WIDTH),
            .LOG2W (LOG2W),
            .K     (gi)
         ) u_stage (
            .clock    (clock),
            .reset    (reset),
            .up_valid (valid_c[gi]),
            .up_data  (data_c[gi]),
            .up_amt   (amt_c[gi]),
            .up_op    (op_c[gi]),
            .down_adv (adv_c[gi+1]),
            .adv      (adv_c[gi]),
            .valid    (valid_c[gi+1]),
            .data     (data_c[gi+1]),
            .amt      (amt_c[gi+1]),
            .op       (op_c[gi+1])
         );
      end
   endgenerate

   assign in_ready  = adv_c[0];
   assign out_valid = valid_c[LOG2W];
   assign out_data  = data_c[LOG2W];

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Self-checking bench for pipelined_barrel_shifter (WIDTH=32).
module tb_pipelined_barrel_shifter;
   import shifter_pkg::*;

   logic        clock = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic [4:0]  in_amt;
   logic [1:0]  in_op;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_q[$];

   always #5 clock = ~clock;

   pipelined_barrel_shifter #(.WIDTH(32)) dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_amt    (in_amt),
      .in_op     (in_op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Whole-amount reference for the random stream.
   function automatic logic [31:0] model_shift(input logic [1:0] op, input logic [4:0] amt,
                                               input logic [31:0] d);
      logic [31:0] r;
      case (op)
         OP_SRA:  r = $unsigned($signed(d) >>> amt);
         OP_SLL:  r = d << amt;
`ifdef SHIFTER_ROTATE_EN
         OP_ROR:  r = (amt == 5'd0) ? d : ((d >> amt) | (d << (6'd32 - {1'b0, amt})));
`endif
         default: r = d >> amt;
      endcase
      return r;
   endfunction

   task automatic run_single(input string tag, input logic [1:0] op, input logic [4:0] amt,
                             input logic [31:0] d, input logic [31:0] exp);
      int edges;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_op     = op;
      in_amt    = amt;
      in_data   = d;
      #1;
      check_val({tag, " in_ready"}, 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      edges = 0;
      while (!out_valid && edges < 20) begin
         tick();
         edges++;
      end
      // Result is consumed on the next edge: accept edge + 5.
      check_val({tag, " latency"}, 32'(edges + 1), 32'd5);
      check_val({tag, " data"}, out_data, exp);
      $display("op=%0d amt=%0d in=%h out=%h exp=%h", op, amt, d, out_data, exp);
      tick();
      check_val({tag, " drained"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      int          idx;
      int          n_sent;
      int          n_recv;
      int          cycles;
      int          seen;
      logic        prev_stall;
      logic [31:0] prev_data;
      logic [31:0] held;
      logic        acc;
      logic        emit;

      reset     = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_amt    = '0;
      in_op     = OP_SRL;
      out_ready = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
      #1;
      check_val("reset out_valid", 32'(out_valid), 32'd0);
      check_val("reset out_data", out_data, 32'd0);
      check_val("reset in_ready", 32'(in_ready), 32'd1);
      tick();

      // Directed vectors, no back-pressure.
      run_single("srl31",   OP_SRL, 5'd31, 32'h8000_0000, 32'h0000_0001);
      run_single("sll4",    OP_SLL, 5'd4,  32'h0000_0001, 32'h0000_0010);
      run_single("sra_neg", OP_SRA, 5'd4,  32'hF000_0000, 32'hFF00_0000);
      run_single("sra_pos", OP_SRA, 5'd4,  32'h7000_0000, 32'h0700_0000);
      run_single("sra31",   OP_SRA, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF);
      run_single("sll31",   OP_SLL, 5'd31, 32'h0000_0001, 32'h8000_0000);
      run_single("srl0",    OP_SRL, 5'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF);
      run_single("sra0",    OP_SRA, 5'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF);
      run_single("sll0",    OP_SLL, 5'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF);
      run_single("ror0",    OP_ROR, 5'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF);
`ifdef SHIFTER_ROTATE_EN
      run_single("ror1",    OP_ROR, 5'd1,  32'h0000_0001, 32'h8000_0000);
      run_single("ror8",    OP_ROR, 5'd8,  32'h1234_5678, 32'h7812_3456);
`else
      run_single("ror1",    OP_ROR, 5'd1,  32'h0000_0001, 32'h0000_0000);
      run_single("ror8",    OP_ROR, 5'd8,  32'h1234_5678, 32'h0012_3456);
`endif

      // Stall: out_ready low for 10 cycles while offering SLL-by-1 ops.
      out_ready = 1'b0;
      idx = 0;
      held = '0;
      for (int c = 0; c < 10; c++) begin
         in_valid = 1'b1;
         in_op    = OP_SLL;
         in_amt   = 5'd1;
         in_data  = 32'(idx + 1);
         #1;
         if (c == 6) held = out_data;
         if (c > 6) check_val("stall hold", out_data, held);
         if (in_ready) begin
            exp_q.push_back(32'((idx + 1) * 2));
            idx++;
         end
         tick();
      end
      check_val("stall accepted", 32'(idx), 32'd5);
      check_val("stall in_ready", 32'(in_ready), 32'd0);
      check_val("stall out_valid", 32'(out_valid), 32'd1);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         check_val("drain valid", 32'(out_valid), 32'd1);
         if (exp_q.size() > 0) begin
            $display("drain %0d out=%h exp=%h", i, out_data, exp_q[0]);
            check_val("drain data", out_data, exp_q.pop_front());
         end
         tick();
      end
      check_val("drain empty", 32'(out_valid), 32'd0);
      exp_q.delete();

      // Random stream with random in_valid / out_ready.
      n_sent = 0;
      n_recv = 0;
      cycles = 0;
      prev_stall = 1'b0;
      prev_data  = '0;
      while (n_recv < 20 && cycles < 2000) begin
         in_valid  = (n_sent < 20) && ($urandom_range(0, 3) != 0);
         in_op     = 2'($urandom_range(0, 3));
         in_amt    = 5'($urandom_range(0, 31));
         in_data   = $urandom;
         out_ready = ($urandom_range(0, 2) != 0);
         #1;
         if (prev_stall) begin
            check_val("stream hold valid", 32'(out_valid), 32'd1);
            check_val("stream hold data", out_data, prev_data);
         end
         acc  = in_valid && in_ready;
         emit = out_valid && out_ready;
         if (emit) begin
            if (exp_q.size() == 0) begin
               check_val("stream spurious", 32'(out_valid), 32'd0);
            end else begin
               $display("stream %0d out=%h exp=%h", n_recv, out_data, exp_q[0]);
               check_val("stream data", out_data, exp_q.pop_front());
            end
            n_recv++;
         end
         if (acc) begin
            exp_q.push_back(model_shift(in_op, in_amt, in_data));
            n_sent++;
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         tick();
         cycles++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check_val("stream received", 32'(n_recv), 32'd20);
      check_val("stream leftover", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      repeat (6) tick();

      // Reset with three operations in flight.
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_op    = OP_SLL;
         in_amt   = 5'd2;
         in_data  = 32'(i + 7);
         tick();
      end
      in_valid = 1'b0;
      reset    = 1'b1;
      tick();
      check_val("midreset out_valid", 32'(out_valid), 32'd0);
      check_val("midreset out_data", out_data, 32'd0);
      reset = 1'b0;
      #1;
      check_val("midreset in_ready", 32'(in_ready), 32'd1);
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         if (out_valid) seen++;
         tick();
      end
      check_val("midreset ghosts", 32'(seen), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
